// File: rtl/mult_arbiter.sv
// Round-robin arbiter feeding a shared two-stage signed 8x8 Booth multiplier.
// Results leave in acceptance order, tagged with the owning requester index.
module mult_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_data,
    output logic [IDW-1:0]    res_id,
    output logic              busy
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           s1_valid_q, s1_valid_d;
    logic [7:0]     s1_a_q, s1_a_d;
    logic [7:0]     s1_b_q, s1_b_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic           s2_valid_q, s2_valid_d;
    logic [15:0]    s2_data_q, s2_data_d;
    logic [IDW-1:0] s2_id_q, s2_id_d;

    logic           s2_load;
    logic           s1_can_load;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic           accept;
    logic [15:0]    product;

    assign s2_load     = !s2_valid_q || res_ready;
    assign s1_can_load = !s1_valid_q || s2_load;

    // First valid requester at or above the pointer, wrapping modulo NREQ
    always_comb begin
        int p;
        p         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            p = int'(ptr_q) + k;
            if (p >= NREQ) p = p - NREQ;
            if (!gnt_found && req_valid[p]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(p);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && s1_can_load && gnt_found) req_ready[gnt_idx] = 1'b1;
    end

    assign accept = |req_ready;

    // Radix-4 Booth: four signed digits of b select 0, +-a, +-2a
    always_comb begin
        logic [8:0]  b_ext;
        logic [15:0] a_ext;
        logic [2:0]  trip;
        logic [15:0] mag;
        logic [15:0] pp;
        logic        neg;
        b_ext   = {s1_b_q, 1'b0};
        a_ext   = {{8{s1_a_q[7]}}, s1_a_q};
        trip    = '0;
        mag     = '0;
        pp      = '0;
        neg     = 1'b0;
        product = '0;
        for (int j = 0; j < 4; j++) begin
            trip = b_ext[2*j +: 3];
            mag  = '0;
            neg  = 1'b0;
            case (trip)
                3'b001, 3'b010: mag = a_ext;
                3'b011:         mag = a_ext << 1;
                3'b100: begin
                    mag = a_ext << 1;
                    neg = 1'b1;
                end
                3'b101, 3'b110: begin
                    mag = a_ext;
                    neg = 1'b1;
                end
                default:        mag = '0;
            endcase
            pp      = neg ? ~mag : mag;
            product = product + (pp << (2*j)) + ({15'b0, neg} << (2*j));
        end
    end

    always_comb begin
        int gi;
        gi         = int'(gnt_idx);
        ptr_d      = ptr_q;
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        if (accept) begin
            ptr_d = (gi + 1 >= NREQ) ? '0 : gnt_idx + IDW'(1);
        end
        if (s1_can_load) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_a_d  = req_a[8*gi +: 8];
                s1_b_d  = req_b[8*gi +: 8];
                s1_id_d = gnt_idx;
            end
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = product;
                s2_id_d   = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
        end
    end

    assign res_valid = s2_valid_q;
    assign res_data  = s2_data_q;
    assign res_id    = s2_id_q;
    assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios, exhaustive products and random
// traffic, all checked against a queue-based reference model.
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [1:0]  res_id;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] prod;
        int          id;
        int          pos;
    } item_t;

    item_t q[$];
    int    ptr = 0;

    always #5 clk = ~clk;

    mult_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mul(input logic [7:0] a, input logic [7:0] b);
        int x;
        x = int'($signed(a)) * int'($signed(b));
        return x[15:0];
    endfunction

    // Compare outputs against the model, then advance the model by one edge
    task automatic model_step();
        bit s2f, s1f, s2l, cl;
        int g, p;
        logic [3:0] er;
        s2f = (q.size() > 0) && (q[0].pos == 2);
        s1f = (q.size() > 0) && (q[q.size()-1].pos == 1);
        chk("res_valid", {31'b0, res_valid}, {31'b0, s2f});
        chk("busy", {31'b0, busy}, {31'b0, q.size() > 0});
        if (s2f) begin
            chk("res_data", {16'b0, res_data}, {16'b0, q[0].prod});
            chk("res_id", {30'b0, res_id}, 32'(q[0].id));
        end
        s2l = !s2f || res_ready;
        cl  = !s1f || s2l;
        g = -1;
        if (cl) begin
            for (int k = 0; k < 4; k++) begin
                p = (ptr + k) % 4;
                if (g < 0 && req_valid[p]) g = p;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", {28'b0, req_ready}, {28'b0, er});
        if (s2f && res_ready) void'(q.pop_front());
        if (s2l && q.size() > 0 && q[q.size()-1].pos == 1)
            q[q.size()-1].pos = 2;
        if (g >= 0) begin
            q.push_back('{mul(req_a[8*g +: 8], req_b[8*g +: 8]), g, 1});
            ptr = (g + 1) % 4;
        end
    endtask

    task automatic cyc();
        #1;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_ops();
        req_a = $urandom;
        req_b = $urandom;
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < n; i++) cyc();
    endtask

    logic [7:0] ca[5];
    logic [7:0] cb[5];
    logic [15:0] ce[5];

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_ready", {28'b0, req_ready}, 32'h0);
        chk("rst_res_valid", {31'b0, res_valid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_data", {16'b0, res_data}, 32'h0);
        chk("rst_id", {30'b0, res_id}, 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        @(negedge clk);

        // Single request on requester 1
        req_valid = 4'b0010;
        req_a     = 32'h0000_8000;
        req_b     = 32'h0000_8000;
        #1;
        chk("single_ready", {28'b0, req_ready}, 32'h2);
        cyc();
        req_valid = '0;
        cyc();
        #1;
        chk("single_valid", {31'b0, res_valid}, 32'h1);
        chk("single_data", {16'b0, res_data}, 32'h4000);
        chk("single_id", {30'b0, res_id}, 32'h1);
        drain(3);

        // Arithmetic corners on requester 0
        ca = '{8'd127, 8'hFF, 8'd0, 8'h80, 8'h80};
        cb = '{8'h80, 8'd1, 8'h80, 8'd127, 8'h80};
        ce = '{16'hC080, 16'hFFFF, 16'h0000, 16'hC080, 16'h4000};
        for (int i = 0; i < 5; i++) begin
            req_valid = 4'b0001;
            req_a     = {24'b0, ca[i]};
            req_b     = {24'b0, cb[i]};
            cyc();
            req_valid = '0;
            cyc();
            #1;
            chk("corner", {16'b0, res_data}, {16'b0, ce[i]});
            cyc();
        end
        drain(2);

        // Round-robin with all four requesting
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            cyc();
        end
        drain(3);

        // Pointer after a lone grant to requester 2
        req_valid = 4'b0100;
        rand_ops();
        cyc();
        req_valid = 4'b1001;
        #1;
        chk("ptr_first", {28'b0, req_ready}, 32'h8);
        cyc();
        #1;
        chk("ptr_second", {28'b0, req_ready}, 32'h1);
        cyc();
        drain(3);

        // Backpressure: two accepted, then outputs frozen
        req_valid = 4'b1111;
        res_ready = 1'b0;
        rand_ops();
        for (int i = 0; i < 4; i++) cyc();
        #1;
        chk("bp_ready", {28'b0, req_ready}, 32'h0);
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        drain(3);

        // Exhaustive product sweep through requester 0
        req_valid = 4'b0001;
        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 0; bi < 256; bi++) begin
                req_a = {24'b0, 8'(ai)};
                req_b = {24'b0, 8'(bi)};
                cyc();
            end
        end
        drain(3);

        // Random traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            req_valid = 4'($urandom);
            res_ready = 1'($urandom);
            rand_ops();
            cyc();
        end
        drain(4);

        // Reset while a result is waiting
        req_valid = 4'b0001;
        res_ready = 1'b0;
        rand_ops();
        cyc();
        cyc();
        #1;
        chk("pre_rst_valid", {31'b0, res_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, res_valid}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        chk("mid_rst_ready", {28'b0, req_ready}, 32'h0);
        chk("mid_rst_data", {16'b0, res_data}, 32'h0);
        q.delete();
        ptr = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        req_valid = 4'b1001;
        #1;
        chk("post_rst_grant", {28'b0, req_ready}, 32'h1);
        cyc();
        cyc();
        drain(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
